// File: rtl/seq_divider.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Start is the falling edge of the active-low load button; divide-by-zero completes one cycle after start.
module seq_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        divByZero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        load_prev_q, load_prev_d;
   logic [15:0] work_q, work_d;
   logic [7:0]  dvsr_q, dvsr_d;
   logic [8:0]  pr_q, pr_d;
   logic [4:0]  count_q, count_d;
   logic [15:0] quot_q, quot_d;
   logic [7:0]  rem_q, rem_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;
   logic        zpend_q, zpend_d;

   logic        start;
   logic [8:0]  pr_shift;
   logic [8:0]  pr_sub;
   logic        fits;
   logic [8:0]  pr_next;
   logic [15:0] work_next;

   assign start    = load_prev_q & ~load;
   assign pr_shift = {pr_q[7:0], work_q[15]};
   assign pr_sub   = pr_shift - {1'b0, dvsr_q};
   assign fits     = (pr_shift >= {1'b0, dvsr_q});
   assign pr_next  = fits ? pr_sub : pr_shift;
   // The dividend register shifts out MSB-first while quotient bits shift in at the LSB.
   assign work_next = {work_q[14:0], fits};

   always_comb begin
      state_d     = state_q;
      load_prev_d = load;
      work_d      = work_q;
      dvsr_d      = dvsr_q;
      pr_d        = pr_q;
      count_d     = count_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      busy_d      = busy_q;
      done_d      = done_q;
      dbz_d       = dbz_q;
      zpend_d     = zpend_q;

      case (state_q)
         RUN: begin
            pr_d    = pr_next;
            work_d  = work_next;
            count_d = count_q + 5'd1;
            if (count_q == 5'd15) begin
               quot_d  = work_next;
               rem_d   = pr_next[7:0];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: begin
            if (zpend_q) begin
               // A zero divisor was latched last cycle; publish the fixed result now.
               quot_d  = 16'hFFFF;
               rem_d   = work_q[7:0];
               done_d  = 1'b1;
               dbz_d   = 1'b1;
               zpend_d = 1'b0;
            end else if (start) begin
               work_d  = dividend;
               dvsr_d  = divisor;
               pr_d    = 9'd0;
               count_d = 5'd0;
               done_d  = 1'b0;
               dbz_d   = 1'b0;
               if (divisor == 8'd0) begin
                  zpend_d = 1'b1;
                  state_d = DONE;
               end else begin
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         load_prev_q <= 1'b1;
         work_q      <= 16'd0;
         dvsr_q      <= 8'd0;
         pr_q        <= 9'd0;
         count_q     <= 5'd0;
         quot_q      <= 16'd0;
         rem_q       <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         zpend_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_prev_q <= load_prev_d;
         work_q      <= work_d;
         dvsr_q      <= dvsr_d;
         pr_q        <= pr_d;
         count_q     <= count_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         zpend_q     <= zpend_d;
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign divByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a cycle-level arithmetic model checked every cycle,
// plus directed operations with hand-computed results.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b1;
   logic [15:0] dividend = 16'd0;
   logic [7:0]  divisor = 8'd0;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        divByZero;

   int checks = 0;
   int errors = 0;
   logic en = 1'b0;

   seq_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .divByZero (divByZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Behavioural model: results come from / and %, timing from a countdown.
   logic [15:0] m_q, m_a;
   logic [7:0]  m_r, m_b;
   logic        m_busy, m_done, m_dbz, m_prev, m_zpend;
   int          m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= 16'd0; m_r <= 8'd0; m_a <= 16'd0; m_b <= 8'd0;
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
         m_prev <= 1'b1; m_zpend <= 1'b0; m_left <= 0;
      end else begin
         m_prev <= load;
         if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_q    <= m_a / {8'd0, m_b};
               m_r    <= 8'(m_a % {8'd0, m_b});
            end
         end else if (m_zpend) begin
            m_zpend <= 1'b0;
            m_done  <= 1'b1;
            m_dbz   <= 1'b1;
            m_q     <= 16'hFFFF;
            m_r     <= m_a[7:0];
         end else if (m_prev && !load) begin
            m_a    <= dividend;
            m_b    <= divisor;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (divisor == 8'd0) m_zpend <= 1'b1;
            else begin
               m_busy <= 1'b1;
               m_left <= 16;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("model_quotient", quotient, m_q);
         chk("model_remainder", remainder, m_r);
         chk("model_busy", busy, m_busy);
         chk("model_done", done, m_done);
         chk("model_divByZero", divByZero, m_dbz);
         chk("busy_done_exclusive", busy & done, 1'b0);
      end
   end

   task automatic press(input logic [15:0] a, input logic [7:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      load     = 1'b0;
      @(negedge clk);
      load     = 1'b1;
   endtask

   // Called at the negedge after the start edge; returns edges elapsed until done.
   task automatic wait_done(input int start_cyc, output int cyc);
      cyc = start_cyc;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic report(input logic [15:0] a, input logic [7:0] b);
      $display("op %0d / %0d -> quotient=%0d remainder=%0d divByZero=%0b", a, b, quotient, remainder, divByZero);
   endtask

   logic [15:0] tab_a [3] = '{16'd1000, 16'd65535, 16'd65025};
   logic [7:0]  tab_b [3] = '{8'd7, 8'd1, 8'd255};
   logic [15:0] tab_q [3] = '{16'd142, 16'd65535, 16'd255};
   logic [7:0]  tab_r [3] = '{8'd6, 8'd0, 8'd0};

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 expected=0");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int busy_cnt;
      #1 rst_n = 1'b0;
      #1 en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_quotient", quotient, 16'd0);
      chk("reset_remainder", remainder, 8'd0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_divByZero", divByZero, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 460 / 23
      press(16'd460, 8'd23);
      chk("busy_after_start", busy, 1'b1);
      wait_done(0, cyc);
      chk("latency_460_23", cyc, 16);
      chk("q_460_23", quotient, 16'd20);
      chk("r_460_23", remainder, 8'd0);
      chk("busy_low_at_done", busy, 1'b0);
      report(16'd460, 8'd23);

      // Back-to-back, each started from DONE
      for (int i = 0; i < 3; i++) begin
         press(tab_a[i], tab_b[i]);
         chk("done_dropped_on_start", done, 1'b0);
         chk("q_held_during_run", quotient, (i == 0) ? 16'd20 : tab_q[i-1]);
         wait_done(0, cyc);
         chk("latency_b2b", cyc, 16);
         chk("q_b2b", quotient, tab_q[i]);
         chk("r_b2b", remainder, tab_r[i]);
         report(tab_a[i], tab_b[i]);
      end

      // Divide by zero
      press(16'd5, 8'd0);
      chk("dz_busy_never", busy, 1'b0);
      chk("dz_done_not_yet", done, 1'b0);
      @(negedge clk);
      chk("dz_done", done, 1'b1);
      chk("dz_flag", divByZero, 1'b1);
      chk("dz_quotient", quotient, 16'hFFFF);
      chk("dz_remainder", remainder, 8'd5);
      chk("dz_busy", busy, 1'b0);
      report(16'd5, 8'd0);

      // Held button with operands changed mid-run
      @(negedge clk);
      dividend = 16'd300;
      divisor  = 8'd10;
      load     = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 2) begin
            dividend = 16'd999;
            divisor  = 8'd3;
         end
         if (busy) busy_cnt++;
      end
      load = 1'b1;
      chk("held_busy_cycles", busy_cnt, 16);
      chk("held_q", quotient, 16'd30);
      chk("held_r", remainder, 8'd0);
      chk("held_dz_cleared", divByZero, 1'b0);
      report(16'd300, 8'd10);

      // Start while busy is ignored
      press(16'd1000, 8'd7);
      repeat (4) @(negedge clk);
      dividend = 16'd460;
      divisor  = 8'd23;
      load     = 1'b0;
      @(negedge clk);
      load     = 1'b1;
      wait_done(5, cyc);
      chk("ignored_start_latency", cyc, 16);
      chk("ignored_start_q", quotient, 16'd142);
      chk("ignored_start_r", remainder, 8'd6);
      report(16'd1000, 8'd7);

      // Reset mid-run
      press(16'd460, 8'd23);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_quotient", quotient, 16'd0);
      chk("async_rst_remainder", remainder, 8'd0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_rst_busy", busy, 1'b0);
      chk("idle_after_rst_done", done, 1'b0);
      press(16'd460, 8'd23);
      wait_done(0, cyc);
      chk("post_rst_latency", cyc, 16);
      chk("post_rst_q", quotient, 16'd20);
      chk("post_rst_r", remainder, 8'd0);
      report(16'd460, 8'd23);

      repeat (2) @(negedge clk);
      en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
